// File: rtl/alu_result_buffer_if.sv
// ---------------------------------------------------------------------------
// alu_result_buffer_if
// Bundles the ALU-result capture side, the feedback/status outputs and the
// readout handshake of alu_result_buffer.
//   slave  : the buffer (consumes ALUout/in_valid/clr/out_ready, drives the rest)
//   master : the environment (ALU + readout logic)
// Signals:
//   ALUout, in_valid, in_ready : producer side, push = in_valid & in_ready
//   clr                        : synchronous clear of FIFO, Q and flags
//   Q, B_fb                    : last accepted result, Q[3:0] fed back to ALU B
//   out_data, out_valid, out_ready : show-ahead FIFO head, pop = out_valid & out_ready
//   count, overflow            : occupancy and sticky lost/refused flag
// ---------------------------------------------------------------------------
interface alu_result_buffer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    logic [W-1:0]             ALUout;
    logic                     in_valid;
    logic                     in_ready;
    logic                     clr;
    logic [W-1:0]             Q;
    logic [3:0]               B_fb;
    logic [W-1:0]             out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport slave (
        input  ALUout, in_valid, clr, out_ready,
        output in_ready, Q, B_fb, out_data, out_valid, count, overflow
    );

    modport master (
        output ALUout, in_valid, clr, out_ready,
        input  in_ready, Q, B_fb, out_data, out_valid, count, overflow
    );
endinterface

// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
// Downstream stage of the 4-bit ALU. Every accepted ALU result is latched in
// Q (Q[3:0] returns to the ALU B operand for accumulate-style chaining) and
// queued in a DEPTH-entry FIFO read out through a valid/ready handshake.
// Ports:
//   Clock   : system clock, rising edge
//   Reset_b : asynchronous active-low reset
//   bus     : alu_result_buffer_if.slave (see interface header)
// Optional build macro:
//   ALU_RESULT_BUF_DROP_OLDEST_EN - in_ready tied high; a push into a full
//   FIFO with no concurrent pop overwrites the oldest entry and sets overflow.
//   Undefined: pushes are refused while full and overflow records the refusal.
// ---------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                Clock,
    input  logic                Reset_b,
    alu_result_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    q_q, q_d;
    logic            ovf_q, ovf_d;

    logic            full, in_ready, push, pop;

    // Flags come from the registered state only, so in_ready never depends
    // combinationally on out_ready.
    assign full = (state_q == S_FULL);

`ifdef ALU_RESULT_BUF_DROP_OLDEST_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = ~full;
`endif

    assign push = bus.in_valid & in_ready;
    assign pop  = (state_q != S_EMPTY) & bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        q_d      = q_q;
        ovf_d    = ovf_q;
        state_d  = state_q;

        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            q_d      = '0;
            ovf_d    = 1'b0;
            state_d  = S_EMPTY;
        end else begin
            // Pointers are AW bits and DEPTH is a power of two: wrap is free.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                q_d      = bus.ALUout;
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

`ifdef ALU_RESULT_BUF_DROP_OLDEST_EN
            // Overwrite the oldest entry: read side steps past it, occupancy holds.
            if (push && full && !pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q;
                ovf_d    = 1'b1;
            end
`else
            if (bus.in_valid && full) ovf_d = 1'b1;
`endif

            case (state_q)
                S_EMPTY:   if (push) state_d = S_PARTIAL;
                S_PARTIAL: begin
                    if (push && !pop && count_q == CW'(DEPTH - 1))
                        state_d = S_FULL;
                    else if (pop && !push && count_q == CW'(1))
                        state_d = S_EMPTY;
                end
                S_FULL:    if (pop && !push) state_d = S_PARTIAL;
                default:   state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; only occupancy decides what is visible.
    always_ff @(posedge Clock) begin
        if (push && !bus.clr) mem[wr_ptr_q] <= bus.ALUout;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.out_data  = mem[rd_ptr_q];
    assign bus.Q         = q_q;
    assign bus.B_fb      = q_q[3:0];
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_buffer
// Directed stimulus against alu_result_buffer. A queue-based model tracks the
// expected contents, Q and overflow; a negedge process compares every output
// to it each cycle, and directed steps pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_alu_result_buffer;
    localparam int DEPTH = 4;
    localparam int W     = 8;
`ifdef ALU_RESULT_BUF_DROP_OLDEST_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic Clock;
    logic Reset_b;

    alu_result_buffer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    alu_result_buffer #(.DEPTH(DEPTH), .W(W)) dut (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .bus     (bus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_Q   = '0;
    bit           m_ovf = 1'b0;
    bit           m_full, m_pop, m_push;

    always @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b || bus.clr) begin
            m_q.delete();
            m_Q   = '0;
            m_ovf = 1'b0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_pop  = (m_q.size() != 0) && bus.out_ready;
            m_push = bus.in_valid && (DROP || !m_full);
            if (bus.in_valid && m_full && !(DROP && m_pop)) m_ovf = 1'b1;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() == DEPTH) void'(m_q.pop_front());
                m_q.push_back(bus.ALUout);
                m_Q = bus.ALUout;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("count",     32'(bus.count),     32'(m_q.size()));
            chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            chk("in_ready",  32'(bus.in_ready),  32'(DROP || m_q.size() != DEPTH));
            chk("Q",         32'(bus.Q),         32'(m_Q));
            chk("B_fb",      32'(bus.B_fb),      32'(m_Q[3:0]));
            chk("overflow",  32'(bus.overflow),  32'(m_ovf));
            if (m_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic c);
        bus.in_valid  = v;
        bus.ALUout    = d;
        bus.out_ready = r;
        bus.clr       = c;
        @(posedge Clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr       = 1'b0;
    endtask

    logic [W-1:0] exp_drain [4];
    logic [W-1:0] exp_head;

    initial begin
        Reset_b       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ALUout    = '0;
        bus.out_ready = 1'b0;
        bus.clr       = 1'b0;
        #23 Reset_b = 1'b1;
        @(posedge Clock);
        #1;
        chk_en = 1'b1;

        // reset state
        chk("rst_count",    32'(bus.count), 0);
        chk("rst_out_valid",32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_Q",        32'(bus.Q), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);

        // single push/pop
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("push_Q",        32'(bus.Q), 32'h3C);
        chk("push_B_fb",     32'(bus.B_fb), 32'hC);
        chk("push_out_valid",32'(bus.out_valid), 1);
        chk("push_out_data", 32'(bus.out_data), 32'h3C);
        chk("push_count",    32'(bus.count), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_count",     32'(bus.count), 0);
        chk("pop_out_valid", 32'(bus.out_valid), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);   // pop while empty is ignored
        chk("empty_pop_count", 32'(bus.count), 0);

        // fill and overflow
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_count",    32'(bus.count), 4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'(DROP));
        cyc(1'b1, 8'h05, 1'b0, 1'b0);
        chk("ovf_flag",  32'(bus.overflow), 1);
        chk("ovf_Q",     32'(bus.Q), DROP ? 32'h05 : 32'h04);
        chk("ovf_count", 32'(bus.count), 4);
        for (int i = 0; i < 4; i++) exp_drain[i] = DROP ? 8'(i + 2) : 8'(i + 1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(bus.out_data), 32'(exp_drain[i]));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_count",    32'(bus.count), 0);
        chk("drain_overflow", 32'(bus.overflow), 1);

        // clr beats a concurrent push
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h23, 1'b0, 1'b0);
        chk("pre_clr_count", 32'(bus.count), 3);
        cyc(1'b1, 8'h7E, 1'b0, 1'b1);
        chk("clr_count",     32'(bus.count), 0);
        chk("clr_overflow",  32'(bus.overflow), 0);
        chk("clr_Q",         32'(bus.Q), 0);
        chk("clr_out_valid", 32'(bus.out_valid), 0);
        chk("clr_in_ready",  32'(bus.in_ready), 1);
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        chk("post_clr_count", 32'(bus.count), 1);
        chk("post_clr_data",  32'(bus.out_data), 32'h10);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // simultaneous push/pop at count 2, with pointer wrap
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("pp_head0", 32'(bus.out_data), 32'h11);
        cyc(1'b1, 8'h22, 1'b1, 1'b0);
        chk("pp_count", 32'(bus.count), 2);
        chk("pp_head1", 32'(bus.out_data), 32'h33);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            exp_head = (i == 0) ? 8'h22 : 8'(8'h40 + i - 1);
            chk("wrap_count", 32'(bus.count), 2);
            chk("wrap_head",  32'(bus.out_data), 32'(exp_head));
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_last", 32'(bus.out_data), 32'h49);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_empty", 32'(bus.count), 0);

        // asynchronous reset mid-cycle with count 2
        cyc(1'b1, 8'h61, 1'b0, 1'b0);
        cyc(1'b1, 8'h62, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 2);
        #2 Reset_b = 1'b0;
        #1;
        chk("arst_count",     32'(bus.count), 0);
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_Q",         32'(bus.Q), 0);
        chk("arst_in_ready",  32'(bus.in_ready), 1);
        #10 Reset_b = 1'b1;
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("after_rst_count", 32'(bus.count), 1);
        chk("after_rst_data",  32'(bus.out_data), 32'h5A);
        chk("after_rst_Q",     32'(bus.Q), 32'h5A);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
